// File: rtl/vol_level_ctrl_if.sv
// ============================================================================
// vol_level_ctrl_if : sample stream in, committed amplitude/level out
// Rev 1.0
// ============================================================================
`default_nettype none

interface vol_level_ctrl_if;
    logic        sample_valid;
    logic [11:0] mic_in;
    logic        frame_begin;
    logic [10:0] num;
    logic [3:0]  level;
    logic        num_update;

    modport master (
        output sample_valid, mic_in, frame_begin,
        input  num, level, num_update
    );

    modport slave (
        input  sample_valid, mic_in, frame_begin,
        output num, level, num_update
    );
endinterface

`default_nettype wire

// File: rtl/vol_level_ctrl.sv
// ============================================================================
// vol_level_ctrl : windowed peak detect, peak-hold/decay, frame-aligned commit
// Rev 1.0
// ============================================================================
`default_nettype none

module vol_level_ctrl #(
    parameter int WINDOW       = 2000,
    parameter int HOLD_WINDOWS = 3,
    parameter int DECAY_STEP   = 205
) (
    input  wire logic        clk,
    input  wire logic        reset,
    vol_level_ctrl_if.slave  bus
);
    localparam int          c_CNT_W     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [c_CNT_W-1:0] c_WIN_LAST = c_CNT_W'(WINDOW - 1);
    localparam logic [3:0]  c_HOLD      = 4'(HOLD_WINDOWS);
    localparam logic [10:0] c_DECAY     = 11'(DECAY_STEP);

    localparam logic [1:0]  c_ST_ACCUM  = 2'd0;
    localparam logic [1:0]  c_ST_EVAL   = 2'd1;
    localparam logic [1:0]  c_ST_PEND   = 2'd2;

    localparam logic [10:0] c_THR [9] = '{11'd205, 11'd409, 11'd614, 11'd819,
        11'd1024, 11'd1229, 11'd1434, 11'd1638, 11'd1842};

    function automatic logic [3:0] f_level(input logic [10:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (v >= c_THR[i]) n = n + 4'd1;
        end
        return n;
    endfunction

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_win_cnt;
    logic [10:0]        r_peak_acc;
    logic [10:0]        r_snap;
    logic [10:0]        r_held;
    logic [3:0]         r_hold_cnt;
    logic               r_pending;
    logic [10:0]        r_num;
    logic [3:0]         r_level;
    logic               r_num_update;

    logic [11:0]        w_diff;
    logic [10:0]        w_amp;
    logic [10:0]        w_peak_max;
    logic [10:0]        w_decayed;
    logic               w_win_end;
    logic               w_eval;
    logic               w_commit;

    // |mic - 2048| reaches 2048 only for mic_in == 0; clamp that to 2047
    always_comb begin
        if (bus.mic_in >= 12'd2048) w_diff = bus.mic_in - 12'd2048;
        else                        w_diff = 12'd2048 - bus.mic_in;
        w_amp      = w_diff[11] ? 11'd2047 : w_diff[10:0];
        w_peak_max = (w_amp > r_peak_acc) ? w_amp : r_peak_acc;
        w_decayed  = (r_held < c_DECAY) ? 11'd0 : r_held - c_DECAY;
        if (r_snap > w_decayed) w_decayed = r_snap;
        w_win_end  = bus.sample_valid && (r_win_cnt == c_WIN_LAST);
        w_eval     = (r_state == c_ST_EVAL);
        w_commit   = bus.frame_begin && r_pending;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_cnt  <= '0;
            r_peak_acc <= 11'd0;
            r_snap     <= 11'd0;
        end else if (bus.sample_valid) begin
            if (w_win_end) begin
                r_snap     <= w_peak_max;
                r_peak_acc <= 11'd0;
                r_win_cnt  <= '0;
            end else begin
                r_peak_acc <= w_peak_max;
                r_win_cnt  <= r_win_cnt + c_CNT_W'(1);
            end
        end
    end

    // A window closing in any state (including PEND) re-runs the evaluation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_ACCUM;
        end else if (w_win_end) begin
            r_state <= c_ST_EVAL;
        end else begin
            case (r_state)
                c_ST_EVAL:  r_state <= c_ST_PEND;
                c_ST_PEND:  if (w_commit) r_state <= c_ST_ACCUM;
                default:    r_state <= c_ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held     <= 11'd0;
            r_hold_cnt <= 4'd0;
        end else if (w_eval) begin
            if (r_snap >= r_held) begin
                r_held     <= r_snap;
                r_hold_cnt <= c_HOLD;
            end else if (r_hold_cnt != 4'd0) begin
                r_hold_cnt <= r_hold_cnt - 4'd1;
            end else begin
                r_held     <= w_decayed;
            end
        end
    end

    // A commit coinciding with eval takes the pre-eval held; eval re-arms pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_num        <= 11'd0;
            r_level      <= 4'd0;
            r_num_update <= 1'b0;
        end else begin
            r_num_update <= w_commit;
            if (w_commit) begin
                r_num   <= r_held;
                r_level <= f_level(r_held);
            end
            if (w_eval)        r_pending <= 1'b1;
            else if (w_commit) r_pending <= 1'b0;
        end
    end

    assign bus.num        = r_num;
    assign bus.level      = r_level;
    assign bus.num_update = r_num_update;

endmodule

`default_nettype wire

// File: tb/tb_vol_level_ctrl.sv
// ============================================================================
// tb_vol_level_ctrl : directed vectors against an in-bench behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_vol_level_ctrl;
    localparam int c_WIN   = 4;
    localparam int c_HOLD  = 1;
    localparam int c_DECAY = 205;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vol_level_ctrl_if bus ();

    vol_level_ctrl #(
        .WINDOW       (c_WIN),
        .HOLD_WINDOWS (c_HOLD),
        .DECAY_STEP   (c_DECAY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int upd_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int amp_of(input int mic);
        int a;
        a = mic - 2048;
        if (a < 0) a = -a;
        return (a > 2047) ? 2047 : a;
    endfunction

    function automatic int level_of(input int v);
        int thr [9] = '{205, 409, 614, 819, 1024, 1229, 1434, 1638, 1842};
        int n = 0;
        foreach (thr[i]) if (v >= thr[i]) n++;
        return n;
    endfunction

    // Behavioural model: window contents kept as a list of amplitudes
    int m_amps [$];
    int m_held = 0, m_hold = 0, m_snap = 0;
    bit m_eval = 0, m_pending = 0;
    int e_num = 0;
    bit e_upd = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_amps.delete();
            m_held = 0; m_hold = 0; m_snap = 0;
            m_eval = 0; m_pending = 0;
            e_num = 0;  e_upd = 0;
        end else begin
            automatic bit commit = bus.frame_begin && m_pending;
            e_upd = commit;
            if (commit) e_num = m_held;
            if (m_eval) begin
                if (m_snap >= m_held) begin
                    m_held = m_snap;
                    m_hold = c_HOLD;
                end else if (m_hold > 0) begin
                    m_hold--;
                end else begin
                    automatic int d = m_held - c_DECAY;
                    if (d < 0) d = 0;
                    m_held = (m_snap > d) ? m_snap : d;
                end
                m_pending = 1;
            end else if (commit) begin
                m_pending = 0;
            end
            m_eval = 0;
            if (bus.sample_valid) begin
                m_amps.push_back(amp_of(int'(bus.mic_in)));
                if (m_amps.size() == c_WIN) begin
                    m_snap = 0;
                    foreach (m_amps[i]) if (m_amps[i] > m_snap) m_snap = m_amps[i];
                    m_amps.delete();
                    m_eval = 1;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("num",        int'(bus.num),        e_num);
        check("level",      int'(bus.level),      level_of(e_num));
        check("num_update", int'(bus.num_update), int'(e_upd));
        if (bus.num_update) upd_cnt++;
    end

    task automatic drive(input logic sv, input logic [11:0] m, input logic fb);
        @(negedge clk);
        bus.sample_valid = sv;
        bus.mic_in       = m;
        bus.frame_begin  = fb;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 12'd2048, 1'b0);
    endtask

    task automatic send_window(input logic [11:0] s0, s1, s2, s3);
        drive(1'b1, s0, 1'b0);
        drive(1'b1, s1, 1'b0);
        drive(1'b1, s2, 1'b0);
        drive(1'b1, s3, 1'b0);
    endtask

    task automatic frame();
        drive(1'b0, 12'd2048, 1'b1);
        drive(1'b0, 12'd2048, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int n, input int lv, input int up);
        check({tag, ".num"},        int'(bus.num),        n);
        check({tag, ".level"},      int'(bus.level),      lv);
        check({tag, ".num_update"}, int'(bus.num_update), up);
    endtask

    initial begin
        int snap_cnt;
        bus.sample_valid = 1'b0;
        bus.mic_in       = 12'd2048;
        bus.frame_begin  = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 0, 0, 0);
        reset = 1'b0;

        // Peak of a mixed window, committed three cycles after window close
        send_window(12'd2048, 12'd2148, 12'd1048, 12'd2048);
        idle(2);
        frame();
        expect_out("peak", 1000, 4, 1);
        idle(1);
        check("peak.pulse_end", int'(bus.num_update), 0);

        // Saturated window; no frame -> num held at old value
        send_window(12'd0, 12'd4095, 12'd2048, 12'd2048);
        idle(5);
        expect_out("defer", 1000, 4, 0);
        frame();
        expect_out("sat", 2047, 9, 1);

        // Hold one window, then linear decay
        do_reset();
        send_window(12'd2048, 12'd1048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("hold.load", 1000, 4, 1);
        send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("hold.kept", 1000, 4, 1);
        send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("decay1", 795, 3, 1);
        send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("decay2", 590, 2, 1);

        // Decay below zero floors at zero
        do_reset();
        send_window(12'd2148, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("floor.load", 100, 0, 1);
        send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("floor.hold", 100, 0, 1);
        send_window(12'd2048, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("floor.zero", 0, 0, 1);

        // frame_begin in the eval cycle with nothing pending is ignored
        do_reset();
        send_window(12'd2348, 12'd2048, 12'd2048, 12'd2048);
        drive(1'b0, 12'd2048, 1'b1);
        drive(1'b0, 12'd2048, 1'b0);
        expect_out("evalframe", 0, 0, 0);
        frame();
        expect_out("evalframe.next", 300, 1, 1);

        // Two windows before a frame -> single commit of the newer held
        idle(1);
        snap_cnt = upd_cnt;
        send_window(12'd2548, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        send_window(12'd2748, 12'd2048, 12'd2048, 12'd2048);
        idle(2);
        frame();
        expect_out("twowin", 700, 3, 1);
        idle(1);
        check("twowin.pulses", upd_cnt - snap_cnt, 1);

        // Asynchronous reset mid-window clears outputs before the next edge
        drive(1'b1, 12'd3548, 1'b0);
        drive(1'b1, 12'd3548, 1'b0);
        @(negedge clk);
        bus.sample_valid = 1'b0;
        #2 reset = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        snap_cnt = upd_cnt;
        repeat (20) begin
            drive(1'b0, 12'd2048, 1'b1);
        end
        idle(1);
        check("rst.no_pulse", upd_cnt - snap_cnt, 0);
        expect_out("rst.quiet", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
